rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one single-ported resource (e.g. the data-memory port) between 8 requesters.
- Grants are one-hot, registered and held until the owner drops its request.
- Sits between requester masters and the shared resource mux; gnt_id drives the mux select directly.
- Any-request detection is an 8-input OR reduction of the eligible request vector.

Parameters:
- MAX_HOLD, 16, maximum consecutive OWN cycles before forced release (used only with ARB_TIMEOUT_EN); legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  8  level request per requester; held high while it wants or uses the resource
- gnt  out  8  registered one-hot grant; all-zero when no owner
- gnt_id  out  3  index of current owner; valid only when gnt_valid=1
- gnt_valid  out  1  OR of gnt
- timeout  out  1  one-cycle pulse when an owner is forcibly released; constant 0 without the macro

Behaviour:
- Reset (reset=1 at a clock edge) forces:
  - state=IDLE
  - gnt=0, gnt_id=0, gnt_valid=0, timeout=0
  - last_id=7, so requester 0 has first priority
  - hold_cnt=0, mask=0
- Reset mid-ownership drops the grant on the next edge. No completion is signalled.
- Eligible vector: elig = req & ~mask. Without the macro, mask is always 0.
- IDLE state:
  - If elig is all-zero, stay in IDLE.
  - Otherwise pick the first set bit of elig, searching in order last_id+1, last_id+2, … mod 8 (wrap from 7 to 0).
  - On the next edge: gnt=onehot(pick), gnt_id=pick, last_id=pick, hold_cnt=0, state=OWN.
  - Latency: req rising at edge t gives gnt at edge t+1.
- OWN state:
  - While req[gnt_id]=1, hold the grant; other requests are ignored.
  - If req[gnt_id]=0 is sampled at edge t, then gnt=0 and state=IDLE at t+1.
  - Earliest next grant is t+2, giving exactly one idle cycle between owners. This is deliberate: a resource turnaround cycle.
- Simultaneous requests: resolved purely by round-robin order.
  - Example: last_id=2 and req=8'b1000_0101 → grant bit 7.
  - A single persistent requester is re-granted after each release plus idle cycle.
- A requester that drops and re-raises req within its own idle gap re-enters arbitration with lowest priority, because last_id equals its index.
- Requests asserted while another requester owns the resource are held off; there is no pre-emption.
- Invariant: gnt always has at most one bit set.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - In OWN, hold_cnt increments every cycle.
  - When hold_cnt==MAX_HOLD-1 and req[gnt_id] is still 1, the next edge forces gnt=0, state=IDLE and timeout=1 for one cycle, and sets mask[gnt_id]=1.
  - A mask bit clears on the first edge at which its req is sampled 0.
  - A masked requester cannot win until it deasserts and re-asserts req.
  - A normal release on the same cycle as the limit is a normal release: no timeout and no mask.
- Without the macro: no counter and no mask register; timeout tied 0; ownership is unbounded.

Decomposition:
- Shared package (hack_arb_pkg) holds:
  - state encoding constants ST_IDLE=0, ST_OWN=1
  - NUM_REQ=8
  - ID_W=3
- Sub-module rr_pick8, purely combinational:
  - Inputs: elig[7:0], last_id[2:0].
  - Outputs: pick[2:0], any.
  - Implementation: rotate elig right by last_id+1, priority-encode the lowest set bit, then add back modulo 8.
  - "any" uses the existing or8way module.

Test Plan:
- Reset/idle: hold reset 3 cycles with req=8'hFF → gnt=0 and gnt_valid=0 during reset; first edge after reset gives gnt=8'h01, gnt_id=0.
- Rotation: req=8'hFF held, each owner drops req for one cycle after 2 cycles of ownership → grant order 0,1,2,…,7,0 with exactly one gnt=0 cycle between owners.
- Wrap/priority: last_id=6, req=8'b0000_0011 → gnt=8'h01 (index 0 wins over 1 after wrap from 7).
- No pre-emption: requester 3 owns; raise req[1] for 10 cycles → gnt stays 8'h08 until req[3] drops, then gnt=8'h02 two edges later.
- Reset mid-operation: reset pulse while gnt=8'h20 → gnt=0 next edge, last_id=7; with req=8'h21 held, the next grant is 8'h01.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=8'h06 held continuously
  - gnt=8'h02 for exactly 4 cycles, then timeout=1 for one cycle and gnt=0.
  - Then gnt=8'h04; requester 1 is not re-granted until req[1] toggles low then high.

Source files
------------

// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: FSM encoding and sizes.
package hack_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/or8way.sv
// 8-input OR reduction.
module or8way (
  input  logic [7:0] in,
  output logic       out
);

  assign out = |in;

endmodule

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set bit of elig after last_id, wrapping 7 -> 0.
module rr_pick8
  import hack_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] elig,
  input  logic [ID_W-1:0]    last_id,
  output logic [ID_W-1:0]    pick,
  output logic               any
);

  logic [ID_W-1:0]    start;
  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    offset;

  assign start = last_id + 3'd1;

  // Rotate so that bit 0 is the highest-priority requester, then take the lowest set bit.
  always_comb begin
    rot    = '0;
    offset = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = elig[3'(i) + start];
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) offset = 3'(i);
    end
  end

  assign pick = offset + start;

  or8way u_any (
    .in  (elig),
    .out (any)
  );

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with registered one-hot grant held until release.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD owned cycles and mask the offender.
module rr_arbiter8
  import hack_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               timeout,
  output arb_state_t         dbg_state
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD must be in 1..255");
  end

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [ID_W-1:0]    id_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [NUM_REQ-1:0] elig;
  logic [ID_W-1:0]    pick;
  logic               any;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0]         hold_q, hold_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic               to_d;

  assign elig = req & ~mask_q;
`else
  assign elig = req;
`endif

  rr_pick8 u_pick (
    .elig    (elig),
    .last_id (last_q),
    .pick    (pick),
    .any     (any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    id_d    = gnt_id;
    last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
    // A mask bit survives only while its requester keeps req high.
    mask_d  = mask_q & req;
    to_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          id_d        = pick;
          last_d      = pick;
          state_d     = ST_OWN;
`ifdef ARB_TIMEOUT_EN
          hold_d      = '0;
`endif
        end
      end
      ST_OWN: begin
        if (!req[gnt_id]) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          gnt_d          = '0;
          state_d        = ST_IDLE;
          to_d           = 1'b1;
          mask_d[gnt_id] = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      last_q  <= 3'd7;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      gnt_id  <= id_d;
      last_q  <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q  <= '0;
      mask_q  <= '0;
      timeout <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      mask_q  <= mask_d;
      timeout <= to_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign gnt_valid = |gnt;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8; outputs are checked 1 time unit after each rising edge.
module tb_rr_arbiter8;
  import hack_arb_pkg::*;

`ifdef ARB_TIMEOUT_EN
  localparam int MAX_HOLD = 4;
`else
  localparam int MAX_HOLD = 16;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;
  arb_state_t dbg_state;

  int n_checks;
  int n_errors;
  logic [2:0] exp_q[$];

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic [7:0] exp_gnt);
    chk({tag, " gnt"}, gnt, exp_gnt);
    chk({tag, " gnt_valid"}, {7'd0, gnt_valid}, {7'd0, |exp_gnt});
    chk({tag, " timeout"}, {7'd0, timeout}, 8'd0);
  endtask

  initial begin
    logic [2:0] e;
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    req      = 8'hFF;

    // reset held 3 cycles with every request high
    for (int i = 0; i < 3; i++) begin
      step();
      chk_gnt("reset", 8'h00);
      chk("reset state", {7'd0, dbg_state}, {7'd0, ST_IDLE});
    end
    reset = 1'b0;
    step();
    chk_gnt("first grant", 8'h01);
    chk("first grant id", {5'd0, gnt_id}, 8'd0);
    chk("first grant state", {7'd0, dbg_state}, {7'd0, ST_OWN});

    // rotation 0..7,0 with one idle cycle between owners
    for (int i = 0; i < 8; i++) exp_q.push_back(3'(i));
    exp_q.push_back(3'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_gnt("rot own", 8'h01 << e);
      chk("rot id", {5'd0, gnt_id}, {5'd0, e});
      step();
      chk_gnt("rot hold", 8'h01 << e);
      req = 8'hFF & ~(8'h01 << e);
      step();
      chk_gnt("rot idle", 8'h00);
      req = 8'hFF;
      step();
    end
    chk_gnt("rot after wrap", 8'h02);
    req = 8'h00;
    step();
    chk_gnt("rot release", 8'h00);

    // wrap: last_id=6, req 0 and 1 -> 0 wins
    req = 8'h40;
    step();
    chk_gnt("set last 6", 8'h40);
    req = 8'h00;
    step();
    req = 8'h03;
    step();
    chk_gnt("wrap priority", 8'h01);
    req = 8'h00;
    step();

    // no pre-emption while requester 3 owns
    req = 8'h08;
    step();
    chk_gnt("owner 3", 8'h08);
    req = 8'h0A;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_gnt("no preempt", 8'h08);
    end
    req = 8'h02;
    step();
    chk_gnt("owner 3 release", 8'h00);
    step();
    chk_gnt("owner 1 after gap", 8'h02);
    chk("owner 1 id", {5'd0, gnt_id}, 8'd1);

    // reset mid-ownership of requester 5
    req = 8'h20;
    step();
    chk_gnt("idle before 5", 8'h00);
    step();
    chk_gnt("owner 5", 8'h20);
    req   = 8'h21;
    reset = 1'b1;
    step();
    chk_gnt("mid reset", 8'h00);
    reset = 1'b0;
    step();
    chk_gnt("after mid reset", 8'h01);

    // simultaneous: last_id=2, req=1000_0101 -> 7
    req = 8'h00;
    step();
    req = 8'h04;
    step();
    chk_gnt("set last 2", 8'h04);
    req = 8'h00;
    step();
    req = 8'h85;
    step();
    chk_gnt("simultaneous", 8'h80);
    chk("simultaneous id", {5'd0, gnt_id}, 8'd7);
    req = 8'h00;
    step();
    chk_gnt("simultaneous release", 8'h00);

`ifdef ARB_TIMEOUT_EN
    // forced release after MAX_HOLD=4 cycles, requester 1 masked afterwards
    req = 8'h06;
    step();
    for (int i = 0; i < 4; i++) begin
      chk_gnt("to own 1", 8'h02);
      if (i < 3) step();
    end
    step();
    chk("to pulse gnt", gnt, 8'h00);
    chk("to pulse", {7'd0, timeout}, 8'd1);
    step();
    chk_gnt("to owner 2", 8'h04);
    req = 8'h02;
    step();
    chk_gnt("owner 2 release", 8'h00);
    step();
    chk_gnt("masked 1 idle", 8'h00);
    req = 8'h00;
    step();
    req = 8'h02;
    step();
    chk_gnt("unmasked 1", 8'h02);
`else
    // ownership is unbounded without the timeout feature
    req = 8'h06;
    step();
    for (int i = 0; i < 20; i++) begin
      chk_gnt("unbounded own", 8'h02);
      step();
    end
    chk_gnt("unbounded end", 8'h02);
`endif

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
